// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry block: key codes, key map and scanner states.
package keypad_entry_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        StScan,
        StDbPress,
        StHeld,
        StDbRel
    } scan_state_e;

    // Key index (4*row + col) to key code; '*' is CLEAR and '#' is ENTER.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = KEY_CLEAR;
            4'd13:   code = 4'h0;
            4'd14:   code = KEY_ENTER;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Index of the lowest active-low row; only meaningful when at least one row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Matrix keypad scanner: row synchronizer, column rotation and press/release debounce.
// Emits a one-cycle press pulse with the key index of each debounced press.
module keypad_scanner
    import keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 23000,
    parameter int unsigned DEBOUNCE_CNT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_idx,
    output logic       press
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]     row_s1, row_s2;
    logic [14:0]    div;
    logic [1:0]     col;
    logic [1:0]     row_sel;
    logic [DbW-1:0] db_cnt;
    scan_state_e    state;

    logic           sample;
    logic           any_low;
    logic           row_low;
    logic [DbW-1:0] db_inc;

    assign sample  = (div == 15'(SCAN_DIV - 1));
    assign any_low = ~&row_s2;
    assign row_low = ~row_s2[row_sel];
    // Saturating increment; reaching DEBOUNCE_CNT completes a debounce.
    assign db_inc  = (db_cnt == DbW'(DEBOUNCE_CNT)) ? db_cnt : db_cnt + DbW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            div     <= '0;
            col     <= 2'd0;
            col_out <= 4'b1110;
            row_sel <= 2'd0;
            db_cnt  <= '0;
            state   <= StScan;
            key_idx <= 4'd0;
            press   <= 1'b0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            div    <= sample ? 15'd0 : div + 15'd1;
            press  <= 1'b0;
            if (sample) begin
                case (state)
                    StScan: begin
                        if (any_low) begin
                            row_sel <= lowest_low(row_s2);
                            db_cnt  <= '0;
                            state   <= StDbPress;
                        end else begin
                            col     <= col + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    StDbPress: begin
                        if (!row_low) begin
                            state <= StScan;
                        end else if (db_inc == DbW'(DEBOUNCE_CNT)) begin
                            press   <= 1'b1;
                            key_idx <= {row_sel, col};
                            db_cnt  <= '0;
                            state   <= StHeld;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                    StHeld: begin
                        if (!row_low) begin
                            db_cnt <= '0;
                            state  <= StDbRel;
                        end
                    end
                    default: begin
                        if (row_low) begin
                            state <= StHeld;
                        end else if (db_inc == DbW'(DEBOUNCE_CNT)) begin
                            db_cnt <= '0;
                            state  <= StScan;
                        end else begin
                            db_cnt <= db_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: decodes debounced presses and assembles up to MAX_DIGITS hex digits.
// '#' commits the value with a one-cycle finish pulse; '*' clears the entry.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 23000,
    parameter int unsigned DEBOUNCE_CNT = 10,
    parameter int unsigned MAX_DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [31:0] keyboard_value,
    output logic        finish,
    output logic [3:0]  digit_cnt,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    logic [3:0] key_idx;
    logic       press;
    logic [3:0] code;
    logic       committed;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scanner (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .key_idx (key_idx),
        .press   (press)
    );

    assign code = key_map(key_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyboard_value <= 32'd0;
            finish         <= 1'b0;
            digit_cnt      <= 4'd0;
            key_valid      <= 1'b0;
            key_code       <= 4'd0;
            committed      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            finish    <= 1'b0;
            if (press) begin
                key_valid <= 1'b1;
                key_code  <= code;
                if (code == KEY_CLEAR) begin
                    keyboard_value <= 32'd0;
                    digit_cnt      <= 4'd0;
                    committed      <= 1'b0;
                end else if (code == KEY_ENTER) begin
                    finish    <= 1'b1;
                    committed <= 1'b1;
                end else if (committed) begin
                    // First digit after a commit starts a fresh entry.
                    keyboard_value <= {28'd0, code};
                    digit_cnt      <= 4'd1;
                    committed      <= 1'b0;
                end else if (digit_cnt < 4'(MAX_DIGITS)) begin
                    keyboard_value <= {keyboard_value[27:0], code};
                    digit_cnt      <= digit_cnt + 4'd1;
                end
            end
        end
    end

endmodule
